// File: rtl/mux_4_1_rr.sv
// rtl/mux_4_1_rr.sv - 4-to-1 round-robin stream combiner with registered, source-tagged output.
// Optional packet locking (hold the grant until in_last) is enabled by defining PKT_LOCK_EN.
module mux_4_1_rr #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  input  logic [3:0]     in_last,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  output logic           out_last,
  input  logic           out_ready
);

  logic [1:0] rr_ptr;
  logic [1:0] gnt_idx;
  logic [1:0] scan_idx;
  logic       gnt_found;
  logic       slot_free;
  logic       accept;

`ifdef PKT_LOCK_EN
  logic       lock;
  logic [1:0] lock_ch;
`endif

  // Search starts at rr_ptr and wraps; the first valid channel wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!gnt_found && in_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
`ifdef PKT_LOCK_EN
    if (lock) begin
      gnt_found = in_valid[lock_ch];
      gnt_idx   = lock_ch;
    end
`endif
  end

  assign slot_free = ~out_valid | out_ready;
  assign accept    = gnt_found & slot_free;
  assign in_ready  = (accept & rst_n) ? (4'b0001 << gnt_idx) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      rr_ptr    <= 2'd0;
`ifdef PKT_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_ch   <= 2'd0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*W +: W];
      out_sel   <= gnt_idx;
      // While locked gnt_idx is lock_ch, so the pointer settles at lock_ch+1 on release.
      rr_ptr    <= gnt_idx + 2'd1;
`ifdef PKT_LOCK_EN
      out_last  <= in_last[gnt_idx];
      lock      <= ~in_last[gnt_idx];
      lock_ch   <= gnt_idx;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef PKT_LOCK_EN
  logic unused_last;
  assign unused_last = ^in_last;
  assign out_last    = 1'b0;
`endif

endmodule
